if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit_if.sv | 24 ++
 rtl/if_fetch_unit.sv | 99 +++++++++
 tb/tb_if_fetch_unit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Instruction-fetch bundle: ID-side control, instruction-memory port and IF/ID outputs.
interface if_fetch_unit_if;
  logic        i_stall;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ready;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_instr;
  logic [31:0] o_pc_4;
  logic        o_valid;
  logic [15:0] o_bubble_count;

  modport master (
    input  i_stall, i_redirect, i_redirect_pc, i_imem_ready, i_imem_rdata,
    output o_imem_req, o_imem_addr, o_instr, o_pc_4, o_valid, o_bubble_count
  );

  modport slave (
    output i_stall, i_redirect, i_redirect_pc, i_imem_ready, i_imem_rdata,
    input  o_imem_req, o_imem_addr, o_instr, o_pc_4, o_valid, o_bubble_count
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC sequencing, stall buffering of an early memory
// response, redirect flush and a saturating bubble counter feeding IF/ID.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  if_fetch_unit_if.master bus
);

  typedef enum logic {S_FETCH, S_HOLD} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] pending, pending_n;
  logic [31:0] instr_p1, instr_n;
  logic [31:0] pc4_p1, pc4_n;
  logic        vld_p1, vld_n;
  logic [15:0] bubble_cnt, bubble_cnt_n;
  logic [31:0] pc_plus4;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign pc_plus4        = pc + 32'd4;
  assign bus.o_imem_req  = (state == S_FETCH);
  assign bus.o_imem_addr = {pc[31:2], 2'b00};

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    pending_n    = pending;
    instr_n      = instr_p1;
    pc4_n        = pc4_p1;
    vld_n        = vld_p1;
    bubble_cnt_n = bubble_cnt;
    if (bus.i_redirect) begin
      // Redirect kills everything in flight, including a same-cycle response.
      state_n      = S_FETCH;
      pc_n         = {bus.i_redirect_pc[31:2], 2'b00};
      pending_n    = 32'd0;
      instr_n      = NOP_INSTR;
      pc4_n        = 32'd0;
      vld_n        = 1'b0;
      bubble_cnt_n = sat_inc(bubble_cnt);
    end else if (state == S_FETCH) begin
      if (bus.i_imem_ready && bus.i_stall) begin
        // Park the response so it is neither lost nor refetched.
        pending_n = bus.i_imem_rdata;
        state_n   = S_HOLD;
      end else if (bus.i_imem_ready) begin
        instr_n = bus.i_imem_rdata;
        pc4_n   = pc_plus4;
        vld_n   = 1'b1;
        pc_n    = pc_plus4;
      end else if (!bus.i_stall) begin
        instr_n      = NOP_INSTR;
        pc4_n        = 32'd0;
        vld_n        = 1'b0;
        bubble_cnt_n = sat_inc(bubble_cnt);
      end
    end else if (!bus.i_stall) begin
      instr_n = pending;
      pc4_n   = pc_plus4;
      vld_n   = 1'b1;
      pc_n    = pc_plus4;
      state_n = S_FETCH;
    end
  end

  // Stage p1: IF/ID register plus fetch control state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      pending    <= 32'd0;
      instr_p1   <= NOP_INSTR;
      pc4_p1     <= 32'd0;
      vld_p1     <= 1'b0;
      bubble_cnt <= 16'd0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      pending    <= pending_n;
      instr_p1   <= instr_n;
      pc4_p1     <= pc4_n;
      vld_p1     <= vld_n;
      bubble_cnt <= bubble_cnt_n;
    end
  end

  assign bus.o_instr        = instr_p1;
  assign bus.o_pc_4         = pc4_p1;
  assign bus.o_valid        = vld_p1;
  assign bus.o_bubble_count = bubble_cnt;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: vector table for the cycle-by-cycle
// behaviour plus hand sequences for async reset and counter saturation.
module tb_if_fetch_unit;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  if_fetch_unit_if bus ();

  if_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Zero-latency memory model: answers the current address.
  assign bus.i_imem_rdata = bus.o_imem_addr ^ 32'hA5A5_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic        ready;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic        e_req;
    logic [31:0] e_addr;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] instr, input logic [31:0] pc4,
                               input logic valid, input logic req, input logic [31:0] addr,
                               input logic [15:0] cnt);
    check({tag, "_instr"}, bus.o_instr, instr);
    check({tag, "_pc4"},   bus.o_pc_4, pc4);
    check({tag, "_valid"}, {31'd0, bus.o_valid}, {31'd0, valid});
    check({tag, "_req"},   {31'd0, bus.o_imem_req}, {31'd0, req});
    check({tag, "_addr"},  bus.o_imem_addr, addr);
    check({tag, "_cnt"},   {16'd0, bus.o_bubble_count}, {16'd0, cnt});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    //          stall redir rpc           rdy  instr          pc4            v     req   addr           cnt
    vecs[0]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hA5A5_0000, 32'h0000_0004, 1'b1, 1'b1, 32'h0000_0004, 16'd0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hA5A5_0004, 32'h0000_0008, 1'b1, 1'b1, 32'h0000_0008, 16'd0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0008, 16'd1};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0008, 16'd2};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hA5A5_0008, 32'h0000_000C, 1'b1, 1'b1, 32'h0000_000C, 16'd2};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'hA5A5_0008, 32'h0000_000C, 1'b1, 1'b0, 32'h0000_000C, 16'd2};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'hA5A5_0008, 32'h0000_000C, 1'b1, 1'b0, 32'h0000_000C, 16'd2};
    vecs[7]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'hA5A5_0008, 32'h0000_000C, 1'b1, 1'b0, 32'h0000_000C, 16'd2};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hA5A5_000C, 32'h0000_0010, 1'b1, 1'b1, 32'h0000_0010, 16'd2};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hA5A5_0010, 32'h0000_0014, 1'b1, 1'b1, 32'h0000_0014, 16'd2};
    vecs[10] = '{1'b1, 1'b1, 32'h0000_0102, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0100, 16'd3};
    vecs[11] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hA5A5_0100, 32'h0000_0104, 1'b1, 1'b1, 32'h0000_0104, 16'd3};
    vecs[12] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'hFFFF_FFFC, 16'd4};
    vecs[13] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h5A5A_FFFC, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 16'd4};
    vecs[14] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hA5A5_0000, 32'h0000_0004, 1'b1, 1'b1, 32'h0000_0004, 16'd4};
    vecs[15] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'hA5A5_0000, 32'h0000_0004, 1'b1, 1'b1, 32'h0000_0004, 16'd4};
    vecs[16] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'hA5A5_0000, 32'h0000_0004, 1'b1, 1'b0, 32'h0000_0004, 16'd4};
    vecs[17] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'hA5A5_0004, 32'h0000_0008, 1'b1, 1'b1, 32'h0000_0008, 16'd4};
    vecs[18] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'hA5A5_0004, 32'h0000_0008, 1'b1, 1'b0, 32'h0000_0008, 16'd4};
    vecs[19] = '{1'b1, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0040, 16'd5};
    vecs[20] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hA5A5_0040, 32'h0000_0044, 1'b1, 1'b1, 32'h0000_0044, 16'd5};

    reset             = 1'b0;
    bus.i_stall       = 1'b0;
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = 32'd0;
    bus.i_imem_ready  = 1'b1;
    step();
    step();
    check_outputs("reset", 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 16'd0);

    reset = 1'b1;
    #1;
    check("release_req",  {31'd0, bus.o_imem_req}, 32'd1);
    check("release_addr", bus.o_imem_addr, 32'h0);

    for (int i = 0; i < NV; i++) begin
      bus.i_stall       = vecs[i].stall;
      bus.i_redirect    = vecs[i].redirect;
      bus.i_redirect_pc = vecs[i].rpc;
      bus.i_imem_ready  = vecs[i].ready;
      step();
      check_outputs($sformatf("v%0d", i), vecs[i].e_instr, vecs[i].e_pc4, vecs[i].e_valid,
                    vecs[i].e_req, vecs[i].e_addr, vecs[i].e_cnt);
    end

    // Enter S_HOLD with a parked response, then pulse reset between edges.
    bus.i_stall      = 1'b1;
    bus.i_redirect   = 1'b0;
    bus.i_imem_ready = 1'b1;
    step();
    check("hold_req", {31'd0, bus.o_imem_req}, 32'd0);
    #3;
    reset = 1'b0;
    #1;
    check_outputs("async_rst", 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 16'd0);
    #1;
    reset       = 1'b1;
    bus.i_stall = 1'b0;
    step();
    check_outputs("post_rst", 32'hA5A5_0000, 32'h4, 1'b1, 1'b1, 32'h4, 16'd0);

    // Counter saturation under a long memory wait.
    bus.i_imem_ready = 1'b0;
    repeat (65534) step();
    check("sat_fffe", {16'd0, bus.o_bubble_count}, 32'h0000_FFFE);
    step();
    check("sat_ffff", {16'd0, bus.o_bubble_count}, 32'h0000_FFFF);
    repeat (5) step();
    check_outputs("sat_hold", 32'h0, 32'h0, 1'b0, 1'b1, 32'h4, 16'hFFFF);
    bus.i_imem_ready = 1'b1;
    step();
    check_outputs("sat_resume", 32'hA5A5_0004, 32'h8, 1'b1, 1'b1, 32'h8, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
